// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO interrupt bank.
//   - Register index encodings as seen in addr[LSB+2:LSB].
//   - Bus handshake FSM state encoding.
package gpio_pkg;

    localparam logic [2:0] GPIO_IN     = 3'd0;
    localparam logic [2:0] GPIO_OUT    = 3'd1;
    localparam logic [2:0] GPIO_EN     = 3'd2;
    localparam logic [2:0] GPIO_MODE   = 3'd3;
    localparam logic [2:0] GPIO_POL    = 3'd4;
    localparam logic [2:0] GPIO_STATUS = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } bus_state_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: multi-flop synchroniser for asynchronous GPIO inputs plus
// rise/fall detection on the synchronised value.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   inp   [W]      asynchronous external inputs
//   sync  [W]      inputs after SYNC_STAGES flops
//   rise  [W]      sync went 0->1 this cycle (vs. previous sync)
//   fall  [W]      sync went 1->0 this cycle
module gpio_sync_edge #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inp,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] chain [SYNC_STAGES];
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
            prev <= '0;
        end else begin
            chain[0] <= inp;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = ~prev & sync;
    assign fall = prev & ~sync;

endmodule

// File: rtl/gpio_irq_bank.sv
// gpio_irq_bank: WIDTH-bit GPIO peripheral on an 8-bit memory bus with
// per-bit interrupt sources (enable, level/edge mode, polarity, W1C status).
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   cs, rd, wr      bus chip select / read / write request
//   addr  [ADDR_W]  byte address (lane in low bits, register index above)
//   data_i [8]      write data byte
//   data_o [8]      read data byte, 0 unless ready on a read
//   ready           handshake acknowledge, held until request drops
//   interrupt       registered OR of (STATUS & EN)
//   inp   [WIDTH]   asynchronous external inputs
//   out   [WIDTH]   OUT register
module gpio_irq_bank
    import gpio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      ADDR_W      = 32,
    parameter int unsigned      LATENCY     = 2,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_i,
    output logic [7:0]        data_o,
    output logic              ready,
    output logic              interrupt,
    input  logic [WIDTH-1:0]  inp,
    output logic [WIDTH-1:0]  out
);

    localparam int unsigned LSB    = $clog2(WIDTH / 8);
    localparam int unsigned LANE_W = (LSB > 0) ? LSB : 1;
    localparam int unsigned IDX_HI = LSB + 3;
    localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    // ------------------------------------------------------------------
    // Address decode of the live bus (latched on accept)
    // ------------------------------------------------------------------
    logic [LANE_W-1:0] bus_lane;
    logic [2:0]        bus_idx;
    logic              bus_req;

    if (LSB > 0) begin : g_lane
        assign bus_lane = addr[LSB-1:0];
    end else begin : g_lane_single
        assign bus_lane = '0;
    end

    if (ADDR_W > IDX_HI) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[ADDR_W-1:IDX_HI];
    end

    assign bus_idx = addr[LSB+2:LSB];
    assign bus_req = cs & (rd | wr);

    // ------------------------------------------------------------------
    // Bus FSM
    // ------------------------------------------------------------------
    bus_state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [2:0]        lat_idx;
    logic [LANE_W-1:0] lat_lane;
    logic [7:0]        lat_data;
    logic              lat_wr;
    logic              entry;      // first cycle spent in DONE
    logic              wr_commit;
    logic [7:0]        rd_byte;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        data_o    = '0;
        unique case (state)
            ST_IDLE: begin
                if (bus_req) begin
                    state_nxt = (LATENCY == 0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                ready = 1'b1;
                if (!lat_wr) begin
                    data_o = rd_byte;
                end
                if (!bus_req) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // rd&wr together latch as a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            lat_idx  <= '0;
            lat_lane <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
            entry    <= 1'b0;
        end else begin
            entry <= (state_nxt == ST_DONE) && (state != ST_DONE);
            if ((state == ST_IDLE) && bus_req) begin
                lat_idx  <= bus_idx;
                lat_lane <= bus_lane;
                lat_data <= data_i;
                lat_wr   <= wr;
                cnt      <= '0;
            end else if (state == ST_WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Writes take effect once, at the end of the first DONE cycle, so a
    // held request in DONE never re-applies a W1C or register write.
    assign wr_commit = (state == ST_DONE) && entry && lat_wr;

    // ------------------------------------------------------------------
    // Byte-lane masks and read mux
    // ------------------------------------------------------------------
    logic [LANE_W+2:0] lane_sh;
    logic [WIDTH-1:0]  wmask;
    logic [WIDTH-1:0]  wval;
    logic [WIDTH-1:0]  rd_word;
    logic [WIDTH-1:0]  rd_shift;

    logic [WIDTH-1:0] out_r, en_r, mode_r, pol_r, status_r;
    logic [WIDTH-1:0] in_sync, in_rise, in_fall;

    assign lane_sh = {lat_lane, 3'b000};
    assign wmask   = WIDTH'(8'hFF) << lane_sh;
    assign wval    = WIDTH'(lat_data) << lane_sh;

    always_comb begin
        rd_word = '0;
        unique case (lat_idx)
            GPIO_IN:     rd_word = in_sync;
            GPIO_OUT:    rd_word = out_r;
            GPIO_EN:     rd_word = en_r;
            GPIO_MODE:   rd_word = mode_r;
            GPIO_POL:    rd_word = pol_r;
            GPIO_STATUS: rd_word = status_r;
            default:     rd_word = '0;
        endcase
    end

    assign rd_shift = rd_word >> lane_sh;
    assign rd_byte  = rd_shift[7:0];

    // ------------------------------------------------------------------
    // Input synchroniser and interrupt sources
    // ------------------------------------------------------------------
    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .inp  (inp),
        .sync (in_sync),
        .rise (in_rise),
        .fall (in_fall)
    );

    logic [WIDTH-1:0] set_vec;
    logic [WIDTH-1:0] clr_vec;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] level_hit;

    assign edge_hit  = (pol_r & in_fall) | (~pol_r & in_rise);
    assign level_hit = in_sync ^ pol_r;
    assign set_vec   = en_r & ((mode_r & edge_hit) | (~mode_r & level_hit));
    assign clr_vec   = (wr_commit && (lat_idx == GPIO_STATUS)) ? wval : '0;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_r     <= OUT_RESET;
            en_r      <= '0;
            mode_r    <= '0;
            pol_r     <= '0;
            status_r  <= '0;
            interrupt <= 1'b0;
        end else begin
            if (wr_commit) begin
                unique case (lat_idx)
                    GPIO_OUT:  out_r  <= (out_r  & ~wmask) | wval;
                    GPIO_EN:   en_r   <= (en_r   & ~wmask) | wval;
                    GPIO_MODE: mode_r <= (mode_r & ~wmask) | wval;
                    GPIO_POL:  pol_r  <= (pol_r  & ~wmask) | wval;
                    default: ;
                endcase
            end
            // Set is OR-ed in after the clear so a same-cycle source wins.
            status_r  <= (status_r & ~clr_vec) | set_vec;
            interrupt <= |(status_r & en_r);
        end
    end

    assign out = out_r;

endmodule
